// File: rtl/regread_pkg.sv
// Shared types and constants for the two-operand register read sequencer.
package regread_pkg;

  localparam int NREGS = 32;
  localparam int IDXW  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    OUT  = 2'd3
  } state_e;

  // Bit offset of entry idx inside the flattened register array bus.
  function automatic int entry_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regread_regsel.sv
// Combinational 32:1 read mux over the flattened register array.
module regsel
  import regread_pkg::*;
#(
  parameter int W = 37
) (
  input  logic [NREGS*W-1:0] regs,
  input  logic [IDXW-1:0]    sel,
  output logic [W-1:0]       rd
);

  logic [W-1:0] entries_s [NREGS];

  for (genvar i = 0; i < NREGS; i++) begin : g_unpack
    assign entries_s[i] = regs[entry_lsb(i, W) +: W];
  end

  assign rd = entries_s[sel];

endmodule

// File: rtl/regread.sv
// Two-operand read sequencer: fetches rs1 then rs2 through one shared read
// port, forwarding same-cycle writes and snooping later ones into held operands.
module regread
  import regread_pkg::*;
#(
  parameter int XLEN = 36
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NREGS*(XLEN+1)-1:0]    regs,
  input  logic [XLEN:0]                G,
  input  logic [XLEN-1:0]              R_in,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [IDXW-1:0]              rs1,
  input  logic [IDXW-1:0]              rs2,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [XLEN:0]                op1,
  output logic [XLEN:0]                op2
);

  localparam int W = XLEN + 1;

  state_e          state_r, state_nx_s;
  logic [IDXW-1:0] rs1_r, rs2_r, sel_s;
  logic [W-1:0]    op1_r, op2_r, op1_nx_s, op2_nx_s, rd_s;
  logic            req_ready_r, rsp_valid_r, req_ready_nx_s, rsp_valid_nx_s;
  logic            hit1_s, hit2_s;

  // Entry 0 reads as zero; a write landing this edge wins over the array output.
  function automatic logic [W-1:0] fwd(input logic [IDXW-1:0] idx,
                                       input logic [XLEN-1:0] wen,
                                       input logic [W-1:0]    g,
                                       input logic [W-1:0]    rd);
    if (idx == 5'd0) begin
      return {W{1'b0}};
    end else if (wen[idx]) begin
      return g;
    end else begin
      return rd;
    end
  endfunction

  // Read port select: rs2 only while capturing op2.
  always_comb begin
    sel_s = rs1_r;
    if (state_r == RD2) begin
      sel_s = rs2_r;
    end else begin
      sel_s = rs1_r;
    end
  end

  regsel #(.W(W)) u_regsel (
    .regs (regs),
    .sel  (sel_s),
    .rd   (rd_s)
  );

  assign hit1_s = (rs1_r != 5'd0) && R_in[rs1_r];
  assign hit2_s = (rs2_r != 5'd0) && R_in[rs2_r];

  // State register and registered handshake outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      req_ready_r <= req_ready_nx_s;
      rsp_valid_r <= rsp_valid_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_nx_s = RD1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RD1: state_nx_s = RD2;
      RD2: state_nx_s = OUT;
      OUT: begin
        if (rsp_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = OUT;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state so they can be registered.
  always_comb begin
    req_ready_nx_s = 1'b0;
    rsp_valid_nx_s = 1'b0;
    case (state_nx_s)
      IDLE:    req_ready_nx_s = 1'b1;
      OUT:     rsp_valid_nx_s = 1'b1;
      default: begin
        req_ready_nx_s = 1'b0;
        rsp_valid_nx_s = 1'b0;
      end
    endcase
  end

  // Operand capture and snoop; operands hold in IDLE.
  always_comb begin
    op1_nx_s = op1_r;
    op2_nx_s = op2_r;
    case (state_r)
      RD1: op1_nx_s = fwd(rs1_r, R_in, G, rd_s);
      RD2: begin
        op2_nx_s = fwd(rs2_r, R_in, G, rd_s);
        if (hit1_s) begin
          op1_nx_s = G;
        end else begin
          op1_nx_s = op1_r;
        end
      end
      OUT: begin
        if (hit1_s) begin
          op1_nx_s = G;
        end else begin
          op1_nx_s = op1_r;
        end
        if (hit2_s) begin
          op2_nx_s = G;
        end else begin
          op2_nx_s = op2_r;
        end
      end
      default: begin
        op1_nx_s = op1_r;
        op2_nx_s = op2_r;
      end
    endcase
  end

  // Datapath registers: latched indices and operands.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rs1_r <= 5'd0;
      rs2_r <= 5'd0;
      op1_r <= {W{1'b0}};
      op2_r <= {W{1'b0}};
    end else begin
      if (state_r == IDLE && req_valid) begin
        rs1_r <= rs1;
        rs2_r <= rs2;
      end else begin
        rs1_r <= rs1_r;
        rs2_r <= rs2_r;
      end
      op1_r <= op1_nx_s;
      op2_r <= op2_nx_s;
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign op1       = op1_r;
  assign op2       = op2_r;

endmodule

// File: tb/tb_regread.sv
// Directed scoreboard bench for regread with an emulated register array.
module tb_regread;

  localparam int XLEN = 36;
  localparam int W    = XLEN + 1;

  typedef struct packed {
    logic [W-1:0] op1;
    logic [W-1:0] op2;
  } exp_t;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic [32*W-1:0]     regs;
  logic [W-1:0]        G = '0;
  logic [XLEN-1:0]     R_in = '0;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [4:0]          rs1 = 5'd0;
  logic [4:0]          rs2 = 5'd0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [W-1:0]        op1, op2;

  logic [W-1:0] model [32];
  exp_t         sb [$];
  int           pass_cnt = 0;
  int           total_cnt = 0;

  regread #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .regs      (regs),
    .G         (G),
    .R_in      (R_in),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .op1       (op1),
    .op2       (op2)
  );

  always #5 clk = ~clk;

  always_comb begin
    regs = '0;
    for (int i = 0; i < 32; i++) regs[i*W +: W] = model[i];
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock with an optional array write; the model updates after the edge.
  task automatic cycle(input bit en, input logic [4:0] widx, input logic [W-1:0] wg);
    if (en) begin
      G = wg;
      R_in = '0;
      R_in[widx] = 1'b1;
    end
    @(posedge clk);
    #1;
    if (en && widx != 5'd0) model[widx] = wg;
    R_in = '0;
  endtask

  // wph: cycle index of the write (0=RD1, 1=RD2, 2+=OUT), -1 for none.
  task automatic xact(input logic [4:0] a, input logic [4:0] b, input int wph,
                      input logic [4:0] widx, input logic [W-1:0] wg, input int hold);
    exp_t e, got;
    int   n;
    e.op1 = model[a];
    e.op2 = model[b];
    if (wph >= 0 && widx != 5'd0) begin
      if (widx == a) e.op1 = wg;
      if (widx == b) e.op2 = wg;
    end
    if (a == 5'd0) e.op1 = '0;
    if (b == 5'd0) e.op2 = '0;
    sb.push_back(e);
    check("accept_ready", W'(req_ready), W'(1'b1));
    req_valid = 1'b1;
    rs1 = a;
    rs2 = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 8) begin
      cycle(n == wph, widx, wg);
      n++;
    end
    check("latency", W'(n), W'(2));
    for (int h = 0; h < hold; h++) begin
      cycle((2 + h) == wph, widx, wg);
      check("held_valid", W'(rsp_valid), W'(1'b1));
    end
    got = sb.pop_front();
    check("op1", op1, got.op1);
    check("op2", op2, got.op2);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("done_valid", W'(rsp_valid), W'(1'b0));
    check("done_ready", W'(req_ready), W'(1'b1));
    check("op1_hold_idle", op1, got.op1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = {5'(i), 32'hA5A5_0000 + 32'(i)};
    model[0] = 37'h1_DEAD_BEEF;
    model[5] = 37'h0_0000_0055;
    model[9] = 37'h1_2345_6789;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", W'(req_ready), W'(1'b1));
    check("rst_rsp_valid", W'(rsp_valid), W'(1'b0));
    check("rst_op1", op1, '0);
    check("rst_op2", op2, '0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    xact(5'd5, 5'd9, -1, 5'd0, '0, 0);                     // basic read
    xact(5'd3, 5'd9, 1, 5'd9, 37'h0_0000_000A, 0);         // forward into RD2 capture
    xact(5'd0, 5'd0, 0, 5'd0, 37'h0_0000_00FF, 0);         // zero register
    xact(5'd5, 5'd9, 2, 5'd5, 37'h0_0000_0077, 2);         // snoop while held
    xact(5'd7, 5'd7, 0, 5'd7, 37'h1F_FFFF_FFFF, 0);        // rs1==rs2, full width
    xact(5'd12, 5'd20, 1, 5'd12, 37'h0_CAFE_F00D, 1);      // op1 snoop during RD2
    xact(5'd14, 5'd14, 1, 5'd14, 37'h15_5555_5555, 0);     // capture + snoop same edge
    xact(5'd20, 5'd12, 0, 5'd12, 37'h0A_AAAA_AAAA, 0);     // RD1 write seen by RD2 read
    xact(5'd31, 5'd1, 3, 5'd1, 37'h10_0000_0001, 2);       // op2 snoop late in OUT

    // Reset in RD2 drops the request.
    req_valid = 1'b1;
    rs1 = 5'd6;
    rs2 = 5'd8;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("midrst_ready", W'(req_ready), W'(1'b1));
    check("midrst_op1", op1, '0);
    check("midrst_op2", op2, '0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("midrst_valid", W'(rsp_valid), W'(1'b0));
    end
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", W'(rsp_valid), W'(1'b0));
    xact(5'd5, 5'd9, -1, 5'd0, '0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
